hash_scheduler: RTL

- Sequencing controller for one looped double-SHA256 hasher pair (first transform plus second transform).
- Accepts mining jobs over a valid/ready handshake: midstate, 96-bit data tail and a nonce range.
- Drives the hasher's state, data, cnt and feedback inputs, and walks the nonce range.
- Qualifies golden tickets and queues lag-corrected golden nonces in a small FIFO for the host-side reader.

---
 rtl/hash_sched_pkg.sv | 18 +
 rtl/hash_scheduler_gn_fifo.sv | 60 ++++++
 rtl/hash_scheduler.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/hash_sched_pkg.sv
// Shared types and SHA-256 constants for the double-SHA256 hash scheduler.
package hash_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } sched_state_t;

   // Block-2 padding for an 80-byte header: 0x80 marker then 640-bit length.
   localparam logic [383:0] SHA256_PAD =
      384'h00000280_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_80000000;

   // Initial hash value seeded into the second transform.
   localparam logic [255:0] SHA256_IV =
      256'h5be0cd19_1f83d9ab_9b05688c_510e527f_a54ff53a_3c6ef372_bb67ae85_6a09e667;

endpackage

// File: rtl/hash_scheduler_gn_fifo.sv
// Golden-nonce FIFO: registered head/valid, sticky overflow on a dropped push.
module gn_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             valid,
   output logic [WIDTH-1:0] head,
   output logic             overflow
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_n, wr_n;
   logic [CNT_W-1:0] count, count_n;
   logic [WIDTH-1:0] head_n;
   logic             push_ok, pop_ok;

   // A pop in the same cycle frees a slot for the push.
   always_comb begin
      pop_ok  = pop && (count != '0);
      push_ok = push && ((count != CNT_W'(DEPTH)) || pop_ok);
      rd_n    = rd_ptr + PTR_W'(pop_ok);
      wr_n    = wr_ptr + PTR_W'(push_ok);
      count_n = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
      head_n  = head;
      if (count_n != '0) begin
         head_n = (push_ok && (rd_n == wr_ptr)) ? push_data : mem[rd_n];
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         valid    <= 1'b0;
         head     <= '0;
         overflow <= 1'b0;
      end else begin
         rd_ptr   <= rd_n;
         wr_ptr   <= wr_n;
         count    <= count_n;
         valid    <= (count_n != '0);
         head     <= head_n;
         overflow <= overflow | (push && !push_ok);
      end
   end

endmodule

// File: rtl/hash_scheduler.sv
// Job sequencer for a looped double-SHA256 hasher pair with golden-nonce queue.
// Optional nonce_count statistics port enabled by defining HASH_SCHED_STATS_EN.
module hash_scheduler
   import hash_sched_pkg::*;
#(
   parameter int unsigned LOOP_LOG2  = 3,
   parameter int unsigned RESULT_LAG = 132,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 job_valid,
   output logic                 job_ready,
   input  logic [255:0]         job_midstate,
   input  logic [95:0]          job_data,
   input  logic [31:0]          job_nonce_start,
   input  logic [31:0]          job_nonce_end,
   output logic [255:0]         hash_state,
   output logic [511:0]         hash_data,
   output logic [LOOP_LOG2-1:0] hash_cnt,
   output logic                 hash_feedback,
   input  logic [31:0]          hash2_top,
   output logic                 busy,
   output logic                 done,
   output logic                 gn_valid,
   input  logic                 gn_ready,
   output logic [31:0]          gn_nonce,
   output logic                 gn_overflow
`ifdef HASH_SCHED_STATS_EN
   ,
   output logic [47:0]          nonce_count
`endif
);

   localparam int unsigned          LAG_W    = $clog2(RESULT_LAG + 1);
   localparam logic [LOOP_LOG2-1:0] CNT_LAST = '1;
   localparam logic [LAG_W-1:0]     LAG_MAX  = LAG_W'(RESULT_LAG);
   localparam logic [LAG_W-1:0]     LAG_LAST = LAG_W'(RESULT_LAG - 1);

   sched_state_t         state, state_n;
   logic [31:0]          nonce, nonce_n, nonce_end, end_n;
   logic [255:0]         midstate, mid_n, hstate_n;
   logic [95:0]          data_tail, tail_n;
   logic [511:0]         hdata_n;
   logic [LAG_W-1:0]     lag, lag_n, drain, drain_n;
   logic [LOOP_LOG2-1:0] cnt_n;
   logic                 fb_n, done_n, golden, golden_n;
   logic [31:0]          golden_nonce, gnonce_n;
   logic                 accept, issue, wrap;

   assign accept = job_valid && job_ready;
   assign issue  = (state != IDLE) && (hash_cnt == '0);
   assign wrap   = (state != IDLE) && (hash_cnt == CNT_LAST);

   // Next-state, nonce walk, lag tracking and golden qualification.
   always_comb begin
      state_n  = state;
      cnt_n    = hash_cnt;
      fb_n     = hash_feedback;
      nonce_n  = nonce;
      end_n    = nonce_end;
      mid_n    = midstate;
      tail_n   = data_tail;
      lag_n    = lag;
      drain_n  = drain;
      hstate_n = hash_state;
      hdata_n  = hash_data;
      done_n   = 1'b0;
      golden_n = 1'b0;
      gnonce_n = nonce - 32'(RESULT_LAG);

      case (state)
         IDLE: cnt_n = '0;
         RUN: begin
            cnt_n = hash_cnt + 1'b1;
            if (wrap) begin
               nonce_n = nonce + 32'd1;
               if (nonce == nonce_end) begin
                  state_n = DRAIN;
                  drain_n = '0;
               end
            end
         end
         DRAIN: begin
            cnt_n = hash_cnt + 1'b1;
            if (wrap) begin
               nonce_n = nonce + 32'd1;
               drain_n = drain + 1'b1;
               if (drain == LAG_LAST) state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase

      if (issue) begin
         hstate_n = midstate;
         hdata_n  = {SHA256_PAD, nonce, data_tail};
         if (lag != LAG_MAX) lag_n = lag + 1'b1;
      end

      // A new job always wins, even over a running one.
      if (accept) begin
         mid_n   = job_midstate;
         tail_n  = job_data;
         end_n   = job_nonce_end;
         nonce_n = job_nonce_start;
         cnt_n   = '0;
         lag_n   = '0;
         drain_n = '0;
         state_n = RUN;
      end

      fb_n     = (cnt_n != '0);
      done_n   = (state_n == DRAIN) && (drain_n == LAG_LAST) && (cnt_n == CNT_LAST);
      golden_n = (hash2_top == '0) && !hash_feedback && (state != IDLE) && (lag == LAG_MAX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         hash_cnt      <= '0;
         hash_feedback <= 1'b0;
         nonce         <= '0;
         nonce_end     <= '0;
         midstate      <= '0;
         data_tail     <= '0;
         lag           <= '0;
         drain         <= '0;
         hash_state    <= '0;
         hash_data     <= '0;
         done          <= 1'b0;
         busy          <= 1'b0;
         job_ready     <= 1'b0;
         golden        <= 1'b0;
         golden_nonce  <= '0;
      end else begin
         state         <= state_n;
         hash_cnt      <= cnt_n;
         hash_feedback <= fb_n;
         nonce         <= nonce_n;
         nonce_end     <= end_n;
         midstate      <= mid_n;
         data_tail     <= tail_n;
         lag           <= lag_n;
         drain         <= drain_n;
         hash_state    <= hstate_n;
         hash_data     <= hdata_n;
         done          <= done_n;
         busy          <= (state_n != IDLE);
         job_ready     <= 1'b1;
         golden        <= golden_n;
         golden_nonce  <= gnonce_n;
      end
   end

   gn_fifo #(
      .DEPTH(FIFO_DEPTH),
      .WIDTH(32)
   ) u_gn_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (golden),
      .push_data(golden_nonce),
      .pop      (gn_ready),
      .valid    (gn_valid),
      .head     (gn_nonce),
      .overflow (gn_overflow)
   );

`ifdef HASH_SCHED_STATS_EN
   logic [47:0] count_n;

   // Nonces issued in RUN for the most recent job.
   always_comb begin
      count_n = nonce_count;
      if (accept) count_n = '0;
      else if (issue && (state == RUN)) count_n = nonce_count + 48'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) nonce_count <= '0;
      else        nonce_count <= count_n;
   end
`endif

endmodule
